pipeline_ctrl_unit: RTL and testbench

Parametrised pipeline control unit for the ARM-style 4-stage datapath (D/E/M/W). It carries a generic control bundle from decode through writeback with flush and condition gating, and holds the NZCV + sticky-Q flag register. Its multi-cycle execute sequencer keeps a long-latency op (MUL/MLA) in E for `MUL_LAT` cycles and requests an upstream stall while doing so. It sits between the instruction decoder and the hazard unit, and generalises the fixed single-cycle controller to configurable bundle width and execute latency.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/cond_eval.sv | 43 ++++
 rtl/pipeline_ctrl_unit.sv | 203 ++++++++++++++++++++
 tb/tb_pipeline_ctrl_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipeline control unit.
//   - ARM condition-code field values (EQ..AL, NV)
//   - bit positions inside the {Q,N,Z,C,V} flag vector
//   - bit positions inside the 3-bit flag_write field
//   - state encoding of the multi-cycle execute sequencer
package ctrl_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Flag vector layout {Q,N,Z,C,V}; N..V also index the 4-bit NZCV slice.
   localparam int FLAG_Q = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // flag_write field layout
   localparam int FW_NZ = 2;
   localparam int FW_CV = 1;
   localparam int FW_Q  = 0;

   typedef enum logic {
      MUL_IDLE = 1'b0,
      MUL_BUSY = 1'b1
   } mulState_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code evaluator.
// Ports:
//   cond  in  4 : ARM condition field
//   nzcv  in  4 : {N,Z,C,V} flags to test against
//   pass  out 1 : 1 when the condition holds (NV never holds)
module cond_eval
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: control pipe for the D/E/M/W datapath.
// Carries an opaque CTRL_W-bit bundle plus write/branch controls from decode
// to writeback, gates them with the E-stage condition result, owns the
// {Q,N,Z,C,V} flag register and holds multi-cycle ops in E for MUL_LAT cycles.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   *_d                   : decode-stage controls (bundle, write enables,
//                           branch/multi flags, flag_write, cond)
//   alu_flags_e           : {Q,N,Z,C,V} produced by the ALU for the op in E
//   flush_e               : clear the E register
//   ctrl_e/m/w            : bundle per stage
//   reg_write_m/w, mem_write_m, pc_src_w : condition-gated stage controls
//   cond_ex_e             : condition result of the op in E
//   flags_q               : architectural flags
//   branch_taken_d        : early branch decision against next-cycle flags
//   stall_e               : E busy; upstream stages must freeze
//   pc_wr_pending_f       : a PC write is somewhere in D/E/M
module pipeline_ctrl_unit
   import ctrl_pkg::*;
#(
   parameter int CTRL_W  = 8,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic              reg_write_d,
   input  logic              mem_write_d,
   input  logic              pc_src_d,
   input  logic              no_write_d,
   input  logic              branch_d,
   input  logic              multi_d,
   input  logic [2:0]        flag_write_d,
   input  logic [3:0]        cond_d,
   input  logic [4:0]        alu_flags_e,
   input  logic              flush_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [CTRL_W-1:0] ctrl_m,
   output logic [CTRL_W-1:0] ctrl_w,
   output logic              reg_write_m,
   output logic              mem_write_m,
   output logic              reg_write_w,
   output logic              pc_src_w,
   output logic              cond_ex_e,
   output logic [4:0]        flags_q,
   output logic              branch_taken_d,
   output logic              stall_e,
   output logic              pc_wr_pending_f
);

   // First BUSY cycle loads MUL_LAT-2 so that entry + BUSY cycles = MUL_LAT.
   localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

   // E stage
   logic [CTRL_W-1:0] ctrlEReg;
   logic              regWriteEReg, memWriteEReg, pcSrcEReg;
   logic              noWriteEReg, multiEReg;
   logic [2:0]        flagWriteEReg;
   logic [3:0]        condEReg;
   // M and W stages
   logic [CTRL_W-1:0] ctrlMReg, ctrlWReg;
   logic              regWriteMReg, memWriteMReg, pcSrcMReg;
   logic              regWriteWReg, pcSrcWReg;
   // flags and sequencer
   logic [4:0]        flagsReg, flagsNext;
   mulState_t         stateReg;
   logic [3:0]        cntReg;

   logic condExE, condD, busy, startMul, killE, completeE;
   logic regWriteGated, memWriteGated, pcSrcGated;

   cond_eval u_condE (.cond(condEReg), .nzcv(flagsReg[3:0]),  .pass(condExE));
   // Early branch looks at the flags the op currently in E is about to write.
   cond_eval u_condD (.cond(cond_d),   .nzcv(flagsNext[3:0]), .pass(condD));

   assign busy      = (stateReg == MUL_BUSY);
   assign startMul  = (stateReg == MUL_IDLE) && multiEReg && condExE && (MUL_LAT > 1);
   assign stall_e   = startMul || (busy && (cntReg != 4'd0));
   // A flush while a multi-cycle op is in progress (including its last
   // cycle) kills it: no flag write and a bubble to M.
   assign killE     = busy && flush_e;
   assign completeE = !stall_e && !killE;

   assign regWriteGated = regWriteEReg & condExE & ~noWriteEReg;
   assign memWriteGated = memWriteEReg & condExE;
   assign pcSrcGated    = pcSrcEReg & condExE;

   always_comb begin
      flagsNext = flagsReg;
      if (completeE && condExE) begin
         if (flagWriteEReg[FW_NZ]) begin
            flagsNext[FLAG_N] = alu_flags_e[FLAG_N];
            flagsNext[FLAG_Z] = alu_flags_e[FLAG_Z];
         end
         if (flagWriteEReg[FW_CV]) begin
            flagsNext[FLAG_C] = alu_flags_e[FLAG_C];
            flagsNext[FLAG_V] = alu_flags_e[FLAG_V];
         end
         // Q is sticky: only ever set here, cleared by reset.
         if (flagWriteEReg[FW_Q])
            flagsNext[FLAG_Q] = flagsReg[FLAG_Q] | alu_flags_e[FLAG_Q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= MUL_IDLE;
         cntReg   <= 4'd0;
      end else begin
         case (stateReg)
            MUL_IDLE: begin
               if (startMul && !flush_e) begin
                  stateReg <= MUL_BUSY;
                  cntReg   <= CNT_INIT;
               end
            end
            MUL_BUSY: begin
               if (flush_e || (cntReg == 4'd0)) begin
                  stateReg <= MUL_IDLE;
                  cntReg   <= 4'd0;
               end else begin
                  cntReg <= cntReg - 4'd1;
               end
            end
            default: begin
               stateReg <= MUL_IDLE;
               cntReg   <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrlEReg      <= '0;
         regWriteEReg  <= 1'b0;
         memWriteEReg  <= 1'b0;
         pcSrcEReg     <= 1'b0;
         noWriteEReg   <= 1'b0;
         multiEReg     <= 1'b0;
         flagWriteEReg <= '0;
         condEReg      <= '0;
         ctrlMReg      <= '0;
         regWriteMReg  <= 1'b0;
         memWriteMReg  <= 1'b0;
         pcSrcMReg     <= 1'b0;
         ctrlWReg      <= '0;
         regWriteWReg  <= 1'b0;
         pcSrcWReg     <= 1'b0;
         flagsReg      <= '0;
      end else begin
         if (flush_e) begin
            ctrlEReg      <= '0;
            regWriteEReg  <= 1'b0;
            memWriteEReg  <= 1'b0;
            pcSrcEReg     <= 1'b0;
            noWriteEReg   <= 1'b0;
            multiEReg     <= 1'b0;
            flagWriteEReg <= '0;
            condEReg      <= '0;
         end else if (!stall_e) begin
            ctrlEReg      <= ctrl_d;
            regWriteEReg  <= reg_write_d;
            memWriteEReg  <= mem_write_d;
            pcSrcEReg     <= pc_src_d;
            noWriteEReg   <= no_write_d;
            multiEReg     <= multi_d;
            flagWriteEReg <= flag_write_d;
            condEReg      <= cond_d;
         end

         if (completeE) begin
            ctrlMReg     <= ctrlEReg;
            regWriteMReg <= regWriteGated;
            memWriteMReg <= memWriteGated;
            pcSrcMReg    <= pcSrcGated;
         end else begin
            ctrlMReg     <= '0;
            regWriteMReg <= 1'b0;
            memWriteMReg <= 1'b0;
            pcSrcMReg    <= 1'b0;
         end

         ctrlWReg     <= ctrlMReg;
         regWriteWReg <= regWriteMReg;
         pcSrcWReg    <= pcSrcMReg;
         flagsReg     <= flagsNext;
      end
   end

   assign ctrl_e          = ctrlEReg;
   assign ctrl_m          = ctrlMReg;
   assign ctrl_w          = ctrlWReg;
   assign reg_write_m     = regWriteMReg;
   assign mem_write_m     = memWriteMReg;
   assign reg_write_w     = regWriteWReg;
   assign pc_src_w        = pcSrcWReg;
   assign cond_ex_e       = condExE;
   assign flags_q         = flagsReg;
   assign branch_taken_d  = branch_d & condD;
   assign pc_wr_pending_f = pc_src_d | pcSrcEReg | pcSrcMReg;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: two lanes (MUL_LAT=3 and MUL_LAT=4) share one
// directed stimulus. Each lane has a behavioural model that tracks the op in
// E by how long it has sat there, compared every cycle, plus literal checks.
module tb_pipeline_ctrl_unit;

   typedef struct packed {
      logic [7:0] ctrl;
      logic rw, mw, pc, nw, br, mul;
      logic [2:0] fw;
      logic [3:0] cond;
   } dop_t;

   typedef struct packed {
      logic [7:0] ctrl;
      logic rw, mw, pc;
   } mop_t;

   typedef struct packed {
      logic [7:0] ce, cm, cw;
      logic rwm, mwm, rww, pcw, cex;
      logic [4:0] fq;
      logic bt, st, pend;
   } obs_t;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       flush = 1'b0;
   logic [4:0] alu   = '0;
   dop_t       din;
   bit         armed = 1'b0;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int lat, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s lat=%0d got=%0h want=%0h t=%0t", name, lat, act, exp, $time);
      end
   endtask

   // ARM conditions come in complementary pairs: cond[3:1] picks the test,
   // cond[0] inverts it; 0xE/0xF are always/never.
   function automatic logic condPass(input logic [3:0] c, input logic [4:0] f);
      logic n, z, cf, v, r;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0]; r = 1'b0;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf & ~z;
         3'd5: r = (n == v);
         3'd6: r = ~z & (n == v);
         default: return (c == 4'hE);
      endcase
      return r ^ c[0];
   endfunction

   function automatic dop_t mk(input logic [7:0] c, input logic [5:0] b,
                               input logic [2:0] fw, input logic [3:0] cond);
      dop_t d;
      d.ctrl = c;
      {d.rw, d.mw, d.pc, d.nw, d.br, d.mul} = b;
      d.fw = fw;
      d.cond = cond;
      return d;
   endfunction

   function automatic dop_t nop();
      return mk(8'h00, 6'b000000, 3'b000, 4'hE);
   endfunction

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         localparam int L = (gi == 0) ? 3 : 4;

         logic [7:0] ce, cm, cw;
         logic       rwm, mwm, rww, pcw, cex, bt, st, pend;
         logic [4:0] fq;

         pipeline_ctrl_unit #(.CTRL_W(8), .MUL_LAT(L)) u_dut (
            .clk(clk), .reset(rst),
            .ctrl_d(din.ctrl), .reg_write_d(din.rw), .mem_write_d(din.mw),
            .pc_src_d(din.pc), .no_write_d(din.nw), .branch_d(din.br),
            .multi_d(din.mul), .flag_write_d(din.fw), .cond_d(din.cond),
            .alu_flags_e(alu), .flush_e(flush),
            .ctrl_e(ce), .ctrl_m(cm), .ctrl_w(cw),
            .reg_write_m(rwm), .mem_write_m(mwm), .reg_write_w(rww),
            .pc_src_w(pcw), .cond_ex_e(cex), .flags_q(fq),
            .branch_taken_d(bt), .stall_e(st), .pc_wr_pending_f(pend)
         );

         // Model state: op in E, cycles it has already spent there, flags, M, W.
         dop_t       mE;
         int         mAge;
         logic [4:0] mFlags;
         mop_t       mM, mW;

         function automatic logic longMul();
            return mE.mul && condPass(mE.cond, mFlags) && (L > 1);
         endfunction

         function automatic logic stallX();
            return longMul() && (mAge < L - 1);
         endfunction

         function automatic logic completes();
            return !stallX() && !(flush && longMul());
         endfunction

         function automatic logic [4:0] flagsNextX();
            logic [4:0] f;
            f = mFlags;
            if (completes() && condPass(mE.cond, mFlags)) begin
               if (mE.fw[2]) f[3:2] = alu[3:2];
               if (mE.fw[1]) f[1:0] = alu[1:0];
               if (mE.fw[0]) f[4] = f[4] | alu[4];
            end
            return f;
         endfunction

         function automatic obs_t expObs();
            obs_t e;
            e.ce   = mE.ctrl;
            e.cm   = mM.ctrl;
            e.cw   = mW.ctrl;
            e.rwm  = mM.rw;
            e.mwm  = mM.mw;
            e.rww  = mW.rw;
            e.pcw  = mW.pc;
            e.cex  = condPass(mE.cond, mFlags);
            e.fq   = mFlags;
            e.bt   = din.br & condPass(din.cond, flagsNextX());
            e.st   = stallX();
            e.pend = din.pc | mE.pc | mM.pc;
            return e;
         endfunction

         always @(posedge clk) begin
            if (rst) begin
               mE <= '0; mAge <= 0; mFlags <= '0; mM <= '0; mW <= '0;
            end else begin
               mFlags <= flagsNextX();
               mW <= mM;
               if (completes()) begin
                  mM.ctrl <= mE.ctrl;
                  mM.rw   <= mE.rw & condPass(mE.cond, mFlags) & ~mE.nw;
                  mM.mw   <= mE.mw & condPass(mE.cond, mFlags);
                  mM.pc   <= mE.pc & condPass(mE.cond, mFlags);
               end else begin
                  mM <= '0;
               end
               if (flush) begin
                  mE <= '0; mAge <= 0;
               end else if (stallX()) begin
                  mAge <= mAge + 1;
               end else begin
                  mE <= din; mAge <= 0;
               end
            end
         end

         task automatic compareAll();
            obs_t e;
            e = expObs();
            chk("ctrl_e", L, 32'(ce), 32'(e.ce));
            chk("ctrl_m", L, 32'(cm), 32'(e.cm));
            chk("ctrl_w", L, 32'(cw), 32'(e.cw));
            chk("reg_write_m", L, 32'(rwm), 32'(e.rwm));
            chk("mem_write_m", L, 32'(mwm), 32'(e.mwm));
            chk("reg_write_w", L, 32'(rww), 32'(e.rww));
            chk("pc_src_w", L, 32'(pcw), 32'(e.pcw));
            chk("cond_ex_e", L, 32'(cex), 32'(e.cex));
            chk("flags_q", L, 32'(fq), 32'(e.fq));
            chk("branch_taken_d", L, 32'(bt), 32'(e.bt));
            chk("stall_e", L, 32'(st), 32'(e.st));
            chk("pc_wr_pending_f", L, 32'(pend), 32'(e.pend));
         endtask

         always @(negedge clk) begin
            if (armed) compareAll();
         end
      end
   endgenerate

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #2;
   endtask

   task automatic issue(input string nm, input dop_t op);
      din = op;
      $display("txn %s ctrl=%h cond=%h t=%0t", nm, op.ctrl, op.cond, $time);
      cyc();
      din = nop();
   endtask

   int stc3, stc4, rwc3, rwc4, rwj3, rwj4;

   initial begin
      din = nop();
      rst = 1'b1;
      cyc();
      armed = 1'b1;
      cyc();
      sample();
      chk("lit_reset_flags", 3, 32'(g_lane[0].fq), 32'h0);
      chk("lit_reset_stall", 4, 32'(g_lane[1].st), 32'h0);
      rst = 1'b0;

      // CMP sets NZ/CV; BEQ in D sees the flags CMP is about to write.
      issue("cmp", mk(8'h11, 6'b000000, 3'b110, 4'hE));
      alu = 5'b00110;
      din = mk(8'h12, 6'b001010, 3'b000, 4'h0);
      $display("txn beq ctrl=12 cond=0 t=%0t", $time);
      sample();
      chk("lit_beq_taken", 3, 32'(g_lane[0].bt), 32'h1);
      chk("lit_beq_taken", 4, 32'(g_lane[1].bt), 32'h1);
      cyc();
      din = nop();
      sample();
      chk("lit_cmp_flags", 3, 32'(g_lane[0].fq), 32'b00110);
      chk("lit_cmp_flags", 4, 32'(g_lane[1].fq), 32'b00110);

      // NE with Z=1: condition fails, multi bit must not stall.
      issue("ne_mul", mk(8'h22, 6'b110001, 3'b110, 4'h1));
      alu = 5'b01000;
      sample();
      chk("lit_ne_cond", 3, 32'(g_lane[0].cex), 32'h0);
      chk("lit_ne_stall", 4, 32'(g_lane[1].st), 32'h0);
      cyc();
      sample();
      chk("lit_ne_rw_m", 3, 32'(g_lane[0].rwm), 32'h0);
      chk("lit_ne_mw_m", 4, 32'(g_lane[1].mwm), 32'h0);
      chk("lit_ne_flags", 3, 32'(g_lane[0].fq), 32'b00110);

      // Sticky Q set, then not cleared by an op reporting Q=0.
      issue("qadd1", mk(8'h33, 6'b100000, 3'b001, 4'hE));
      alu = 5'b10000;
      din = mk(8'h34, 6'b100000, 3'b001, 4'hE);
      $display("txn qadd2 ctrl=34 cond=e t=%0t", $time);
      cyc();
      din = nop();
      alu = 5'b00000;
      sample();
      chk("lit_q_set", 3, 32'(g_lane[0].fq), 32'b10110);
      cyc();
      sample();
      chk("lit_q_sticky", 4, 32'(g_lane[1].fq), 32'b10110);

      // Single MUL: count stall cycles and where reg_write_m pulses.
      issue("mul", mk(8'h44, 6'b100001, 3'b000, 4'hE));
      stc3 = 0; stc4 = 0; rwc3 = 0; rwc4 = 0; rwj3 = -1; rwj4 = -1;
      for (int j = 0; j < 8; j++) begin
         sample();
         if (g_lane[0].st) stc3++;
         if (g_lane[1].st) stc4++;
         if (g_lane[0].rwm) begin rwc3++; rwj3 = j; end
         if (g_lane[1].rwm) begin rwc4++; rwj4 = j; end
         cyc();
      end
      chk("lit_mul_stall_cycles", 3, 32'(stc3), 32'd2);
      chk("lit_mul_stall_cycles", 4, 32'(stc4), 32'd3);
      chk("lit_mul_rw_pulses", 4, 32'(rwc4), 32'd1);
      chk("lit_mul_rw_offset", 4, 32'(rwj4), 32'd4);
      chk("lit_mul_rw_offset", 3, 32'(rwj3), 32'd3);

      // Back-to-back MULs: D holds the second until the first completes.
      issue("mul_a", mk(8'h54, 6'b100001, 3'b000, 4'hE));
      din = mk(8'h55, 6'b100001, 3'b000, 4'hE);
      $display("txn mul_b ctrl=55 cond=e t=%0t", $time);
      repeat (4) cyc();
      sample();
      chk("lit_b2b_entry_ctrl", 4, 32'(g_lane[1].ce), 32'h55);
      chk("lit_b2b_entry_stall", 4, 32'(g_lane[1].st), 32'h1);
      din = nop();
      repeat (8) cyc();

      // Flush in the second cycle of a flag-setting MUL.
      issue("mul_flush", mk(8'h66, 6'b101001, 3'b110, 4'hE));
      alu = 5'b01010;
      cyc();
      flush = 1'b1;
      din = mk(8'h67, 6'b001000, 3'b000, 4'hE);
      sample();
      chk("lit_flush_stall_before", 3, 32'(g_lane[0].st), 32'h1);
      cyc();
      flush = 1'b0;
      din = nop();
      sample();
      chk("lit_flush_stall_after", 3, 32'(g_lane[0].st), 32'h0);
      chk("lit_flush_flags", 3, 32'(g_lane[0].fq), 32'b10110);
      chk("lit_flush_flags", 4, 32'(g_lane[1].fq), 32'b10110);
      for (int j = 0; j < 4; j++) begin
         cyc();
         sample();
         chk("lit_flush_rw_m", 3, 32'(g_lane[0].rwm), 32'h0);
         chk("lit_flush_rw_m", 4, 32'(g_lane[1].rwm), 32'h0);
      end

      // Reset while a MUL is busy.
      issue("add", mk(8'h70, 6'b100000, 3'b000, 4'hE));
      issue("mul_rst", mk(8'h77, 6'b100001, 3'b000, 4'hE));
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      sample();
      chk("lit_rst_stall", 3, 32'(g_lane[0].st), 32'h0);
      chk("lit_rst_stall", 4, 32'(g_lane[1].st), 32'h0);
      chk("lit_rst_flags", 3, 32'(g_lane[0].fq), 32'h0);
      chk("lit_rst_ctrl_e", 4, 32'(g_lane[1].ce), 32'h0);
      chk("lit_rst_rw_m", 4, 32'(g_lane[1].rwm), 32'h0);
      chk("lit_rst_rw_w", 4, 32'(g_lane[1].rww), 32'h0);
      chk("lit_rst_ctrl_w", 3, 32'(g_lane[0].cw), 32'h0);

      // Normal traffic after reset.
      issue("post", mk(8'h88, 6'b110000, 3'b110, 4'hE));
      alu = 5'b01001;
      issue("post_hi", mk(8'h89, 6'b101000, 3'b000, 4'h8));
      repeat (4) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
